// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Free-running VGA raster timing generator. A clock divider produces a
//   one-clk pixel strobe (pix_en). Horizontal and vertical counters advance on
//   that strobe. Sync, display-enable and colour are registered one pixel
//   period behind the x/y counts.
//
// Ports
//   clk          system clock, all state on the rising edge
//   rst          asynchronous active-high reset
//   r_in/g_in/b_in  4-bit pixel colour for the current x,y
//   test_mode    selects built-in colour bars (only with VGA_PATTERN_EN)
//   x, y         current horizontal / vertical count (no latency)
//   pix_en       one-clk strobe per pixel period
//   hsync/vsync  registered sync outputs, active level = SYNC_POL
//   de           registered display enable
//   r/g/b        registered colour, zero outside the active area
//   frame_start  one-clk pulse after the counters wrap to (0,0)
//
// Configuration
//   Define VGA_PATTERN_EN to build the 8-bar test pattern generator. Without
//   it, test_mode is ignored and the colour inputs always pass through.

module vga_timing_gen #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter int CLK_DIV  = 4,
  parameter int SYNC_POL = 0
) (
  input  logic                                               clk,
  input  logic                                               rst,
  input  logic [3:0]                                         r_in,
  input  logic [3:0]                                         g_in,
  input  logic [3:0]                                         b_in,
  input  logic                                               test_mode,
  output logic [$clog2(H_ACTIVE+H_FP+H_SYNC+H_BP)-1:0]       x,
  output logic [$clog2(V_ACTIVE+V_FP+V_SYNC+V_BP)-1:0]       y,
  output logic                                               pix_en,
  output logic                                               hsync,
  output logic                                               vsync,
  output logic                                               de,
  output logic [3:0]                                         r,
  output logic [3:0]                                         g,
  output logic [3:0]                                         b,
  output logic                                               frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int XW      = $clog2(H_TOTAL);
  localparam int YW      = $clog2(V_TOTAL);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [XW-1:0] H_LAST   = XW'(H_TOTAL - 1);
  localparam logic [YW-1:0] V_LAST   = YW'(V_TOTAL - 1);

  // One extra bit so sync/active bounds equal to the total still fit.
  localparam logic [XW:0] H_ACT_END = (XW+1)'(H_ACTIVE);
  localparam logic [XW:0] HS_START  = (XW+1)'(H_ACTIVE + H_FP);
  localparam logic [XW:0] HS_END    = (XW+1)'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [YW:0] V_ACT_END = (YW+1)'(V_ACTIVE);
  localparam logic [YW:0] VS_START  = (YW+1)'(V_ACTIVE + V_FP);
  localparam logic [YW:0] VS_END    = (YW+1)'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic SYNC_ON = (SYNC_POL != 0);

  logic [DW-1:0] div_cnt;
  logic [DW-1:0] div_next;
  logic [XW-1:0] h_cnt;
  logic [YW-1:0] v_cnt;
  logic          h_end;
  logic          v_end;
  logic          raw_active;
  logic          raw_hsync;
  logic          raw_vsync;
  logic [3:0]    sel_r;
  logic [3:0]    sel_g;
  logic [3:0]    sel_b;

  assign x = h_cnt;
  assign y = v_cnt;

  // Divider wraps at CLK_DIV-1; with CLK_DIV=1 it stays at zero.
  always_comb begin
    div_next = (div_cnt == DIV_LAST) ? '0 : div_cnt + 1'b1;
  end

  // pix_en is registered alongside the divider so it is high exactly while
  // the divider sits at its last value, and low during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt <= '0;
      pix_en  <= 1'b0;
    end else begin
      div_cnt <= div_next;
      pix_en  <= (div_next == DIV_LAST);
    end
  end

  always_comb begin
    h_end      = (h_cnt == H_LAST);
    v_end      = (v_cnt == V_LAST);
    raw_active = ({1'b0, h_cnt} < H_ACT_END) && ({1'b0, v_cnt} < V_ACT_END);
    raw_hsync  = ({1'b0, h_cnt} >= HS_START) && ({1'b0, h_cnt} < HS_END);
    raw_vsync  = ({1'b0, v_cnt} >= VS_START) && ({1'b0, v_cnt} < VS_END);
  end

  // Raster counters advance once per pixel strobe.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_en) begin
      if (h_end) begin
        h_cnt <= '0;
        v_cnt <= v_end ? '0 : v_cnt + 1'b1;
      end else begin
        h_cnt <= h_cnt + 1'b1;
      end
    end
  end

`ifdef VGA_PATTERN_EN
  logic [2:0] bar_idx;
  logic [3:0] bar_r;
  logic [3:0] bar_g;
  logic [3:0] bar_b;

  // Bar k covers x in [k*H_ACTIVE/8, (k+1)*H_ACTIVE/8). The colour order
  // white, yellow, cyan, green, magenta, red, blue, black maps to
  // r = ~idx[1], g = ~idx[2], b = ~idx[0].
  always_comb begin
    bar_idx = 3'd0;
    for (int k = 1; k < 8; k++) begin
      if ({1'b0, h_cnt} >= (XW+1)'(k * H_ACTIVE / 8)) bar_idx = 3'(k);
    end
    bar_r = {4{~bar_idx[1]}};
    bar_g = {4{~bar_idx[2]}};
    bar_b = {4{~bar_idx[0]}};
    sel_r = test_mode ? bar_r : r_in;
    sel_g = test_mode ? bar_g : g_in;
    sel_b = test_mode ? bar_b : b_in;
  end
`else
  logic unused_test_mode;
  assign unused_test_mode = test_mode;

  always_comb begin
    sel_r = r_in;
    sel_g = g_in;
    sel_b = b_in;
  end
`endif

  // Video outputs sample the current counts on the strobe, so they trail
  // x/y by exactly one pixel period and hold in between.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hsync <= ~SYNC_ON;
      vsync <= ~SYNC_ON;
      de    <= 1'b0;
      r     <= 4'h0;
      g     <= 4'h0;
      b     <= 4'h0;
    end else if (pix_en) begin
      hsync <= raw_hsync ? SYNC_ON : ~SYNC_ON;
      vsync <= raw_vsync ? SYNC_ON : ~SYNC_ON;
      de    <= raw_active;
      r     <= raw_active ? sel_r : 4'h0;
      g     <= raw_active ? sel_g : 4'h0;
      b     <= raw_active ? sel_b : 4'h0;
    end
  end

  // Pulse once, in the cycle after the strobe that leaves the last pixel of
  // the frame. Reset starts at (0,0) without passing through a wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_start <= 1'b0;
    end else begin
      frame_start <= pix_en && h_end && v_end;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Three instances of vga_timing_gen with different timings:
//     A: default horizontal timing, CLK_DIV=4, short 7-line frame
//     B: 14x7 raster, CLK_DIV=1, active-high sync
//     C: 14-pixel lines, default 525-line vertical timing, CLK_DIV=2
//   Every cycle an expected output word per instance, derived from the number
//   of clocks since reset release, is queued and later compared at the
//   falling edge. Colour/bar vectors and multi-cycle corner cases follow.

module tb_vga_timing_gen;

  localparam int A_HA = 640, A_HF = 16, A_HS = 96, A_HB = 48;
  localparam int A_VA = 4, A_VF = 1, A_VS = 1, A_VB = 1;
  localparam int A_DIV = 4;
  localparam int B_HA = 8, B_HF = 2, B_HS = 2, B_HB = 2;
  localparam int B_VA = 4, B_VF = 1, B_VS = 1, B_VB = 1;
  localparam int B_DIV = 1;
  localparam int C_HA = 8, C_HF = 2, C_HS = 2, C_HB = 2;
  localparam int C_VA = 480, C_VF = 10, C_VS = 2, C_VB = 33;
  localparam int C_DIV = 2;
  localparam int WAIT_LIMIT = 40000;

`ifdef VGA_PATTERN_EN
  localparam bit PATTERN_ON = 1'b1;
`else
  localparam bit PATTERN_ON = 1'b0;
`endif

  typedef struct packed {
    logic [9:0]  x;
    logic [9:0]  y;
    logic        pix_en;
    logic        hsync;
    logic        vsync;
    logic        de;
    logic        frame_start;
    logic [11:0] rgb;
  } exp_t;

  typedef struct {
    exp_t e;
    exp_t care;
  } sb_t;

  typedef struct {
    logic        tm;
    logic [11:0] rgb_in;
    int          tx;
    int          ty;
    logic        de;
    logic [11:0] rgb;
  } vec_t;

  logic clk = 1'b0;
  logic rst_a;
  logic rst_bc;

  logic [3:0] a_r_in, a_g_in, a_b_in;
  logic       a_test_mode;
  logic [9:0] a_x;
  logic [2:0] a_y;
  logic       a_pix_en, a_hsync, a_vsync, a_de, a_frame_start;
  logic [3:0] a_r, a_g, a_b;

  logic [3:0] b_x;
  logic [2:0] b_y;
  logic       b_pix_en, b_hsync, b_vsync, b_de, b_frame_start;
  logic [3:0] b_r, b_g, b_b;

  logic [3:0] c_x;
  logic [9:0] c_y;
  logic       c_pix_en, c_hsync, c_vsync, c_de, c_frame_start;
  logic [3:0] c_r, c_g, c_b;

  int checks = 0;
  int errors = 0;
  int n_a = 0;
  int n_bc = 0;
  sb_t sb_a[$];
  sb_t sb_b[$];
  sb_t sb_c[$];
  vec_t vecs[13];

  always #5 clk = ~clk;

  vga_timing_gen #(
    .H_ACTIVE(A_HA), .H_FP(A_HF), .H_SYNC(A_HS), .H_BP(A_HB),
    .V_ACTIVE(A_VA), .V_FP(A_VF), .V_SYNC(A_VS), .V_BP(A_VB),
    .CLK_DIV(A_DIV), .SYNC_POL(0)
  ) dut_a (
    .clk(clk), .rst(rst_a), .r_in(a_r_in), .g_in(a_g_in), .b_in(a_b_in),
    .test_mode(a_test_mode), .x(a_x), .y(a_y), .pix_en(a_pix_en),
    .hsync(a_hsync), .vsync(a_vsync), .de(a_de), .r(a_r), .g(a_g), .b(a_b),
    .frame_start(a_frame_start)
  );

  vga_timing_gen #(
    .H_ACTIVE(B_HA), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_ACTIVE(B_VA), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB),
    .CLK_DIV(B_DIV), .SYNC_POL(1)
  ) dut_b (
    .clk(clk), .rst(rst_bc), .r_in(4'hA), .g_in(4'h5), .b_in(4'h3),
    .test_mode(1'b0), .x(b_x), .y(b_y), .pix_en(b_pix_en),
    .hsync(b_hsync), .vsync(b_vsync), .de(b_de), .r(b_r), .g(b_g), .b(b_b),
    .frame_start(b_frame_start)
  );

  vga_timing_gen #(
    .H_ACTIVE(C_HA), .H_FP(C_HF), .H_SYNC(C_HS), .H_BP(C_HB),
    .V_ACTIVE(C_VA), .V_FP(C_VF), .V_SYNC(C_VS), .V_BP(C_VB),
    .CLK_DIV(C_DIV), .SYNC_POL(0)
  ) dut_c (
    .clk(clk), .rst(rst_bc), .r_in(4'h7), .g_in(4'hC), .b_in(4'h1),
    .test_mode(1'b0), .x(c_x), .y(c_y), .pix_en(c_pix_en),
    .hsync(c_hsync), .vsync(c_vsync), .de(c_de), .r(c_r), .g(c_g), .b(c_b),
    .frame_start(c_frame_start)
  );

  // Pixels consumed after n rising edges out of reset: a strobe is raised by
  // edge m when (m+1) is a multiple of the divisor and consumed at edge m+1.
  function automatic int pixels(input int n, input int d);
    if (n <= 0) return 0;
    return n / d - ((d == 1) ? 1 : 0);
  endfunction

  function automatic exp_t model(input int n, input int d,
                                 input int ha, input int hf, input int hs, input int hb,
                                 input int va, input int vf, input int vs, input int vb,
                                 input logic pol, input logic [11:0] rgb_in);
    int ht, vt, p, q, px, py;
    exp_t e;
    ht = ha + hf + hs + hb;
    vt = va + vf + vs + vb;
    p = pixels(n, d);
    e.x = 10'(p % ht);
    e.y = 10'((p / ht) % vt);
    e.pix_en = (n >= 1) && ((n + 1) % d == 0);
    e.hsync = ~pol;
    e.vsync = ~pol;
    e.de = 1'b0;
    e.frame_start = 1'b0;
    e.rgb = 12'h000;
    if (p >= 1) begin
      q = p - 1;
      px = q % ht;
      py = (q / ht) % vt;
      e.de = (px < ha) && (py < va);
      if (px >= ha + hf && px < ha + hf + hs) e.hsync = pol;
      if (py >= va + vf && py < va + vf + vs) e.vsync = pol;
      if (e.de) e.rgb = rgb_in;
      e.frame_start = (p != pixels(n - 1, d)) && (p % (ht * vt) == 0);
    end
    return e;
  endfunction

  function automatic logic [11:0] barColour(input int idx);
    case (idx)
      0: return 12'hFFF;
      1: return 12'hFF0;
      2: return 12'h0FF;
      3: return 12'h0F0;
      4: return 12'hF0F;
      5: return 12'hF00;
      6: return 12'h00F;
      default: return 12'h000;
    endcase
  endfunction

  function automatic vec_t mkVec(input logic tm, input logic [11:0] rgb_in,
                                 input int tx, input int ty);
    vec_t v;
    v.tm = tm;
    v.rgb_in = rgb_in;
    v.tx = tx;
    v.ty = ty;
    v.de = (tx < A_HA) && (ty < A_VA);
    if (!v.de) v.rgb = 12'h000;
    else if (tm && PATTERN_ON) v.rgb = barColour(tx / (A_HA / 8));
    else v.rgb = rgb_in;
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] got,
                             input logic [63:0] expv, input logic [63:0] care);
    checks++;
    if (((got ^ expv) & care) !== 64'd0) begin
      errors++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, got & care, expv & care);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: got no event, expected one within %0d cycles", name, WAIT_LIMIT);
  endtask

  // Drive instance A colour inputs, then wait for the strobe at (tx,ty).
  task automatic applyStimulus(input vec_t v, output bit found);
    a_test_mode = v.tm;
    a_r_in = v.rgb_in[11:8];
    a_g_in = v.rgb_in[7:4];
    a_b_in = v.rgb_in[3:0];
    found = 1'b0;
    for (int i = 0; i < WAIT_LIMIT && !found; i++) begin
      @(negedge clk);
      if (a_pix_en && int'(a_x) == v.tx && int'(a_y) == v.ty) found = 1'b1;
    end
  endtask

  // Producer: one expected word per instance per clock edge.
  initial begin
    sb_t s;
    forever begin
      @(posedge clk);
      if (rst_a) n_a = 0; else n_a++;
      if (rst_bc) n_bc = 0; else n_bc++;
      #1;
      s.e = model(n_a, A_DIV, A_HA, A_HF, A_HS, A_HB, A_VA, A_VF, A_VS, A_VB, 1'b0, 12'h000);
      s.care = '1;
      if (s.e.de) s.care.rgb = 12'h000;
      sb_a.push_back(s);
      s.e = model(n_bc, B_DIV, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB, 1'b1, 12'hA53);
      s.care = '1;
      sb_b.push_back(s);
      s.e = model(n_bc, C_DIV, C_HA, C_HF, C_HS, C_HB, C_VA, C_VF, C_VS, C_VB, 1'b0, 12'h7C1);
      s.care = '1;
      sb_c.push_back(s);
    end
  end

  // Consumer: compare at the falling edge, away from the active edge.
  initial begin
    sb_t s;
    forever begin
      @(negedge clk);
      if (sb_a.size() > 0) begin
        s = sb_a.pop_front();
        checkOutput("sb_a", 64'({10'(a_x), 10'(a_y), a_pix_en, a_hsync, a_vsync, a_de,
                                 a_frame_start, a_r, a_g, a_b}), 64'(s.e), 64'(s.care));
      end
      if (sb_b.size() > 0) begin
        s = sb_b.pop_front();
        checkOutput("sb_b", 64'({10'(b_x), 10'(b_y), b_pix_en, b_hsync, b_vsync, b_de,
                                 b_frame_start, b_r, b_g, b_b}), 64'(s.e), 64'(s.care));
      end
      if (sb_c.size() > 0) begin
        s = sb_c.pop_front();
        checkOutput("sb_c", 64'({10'(c_x), 10'(c_y), c_pix_en, c_hsync, c_vsync, c_de,
                                 c_frame_start, c_r, c_g, c_b}), 64'(s.e), 64'(s.care));
      end
    end
  end

  initial begin
    bit found;
    int elapsed;
    int low_len;
    logic prev;

    vecs[0]  = mkVec(1'b0, 12'hA53, 0,   0);
    vecs[1]  = mkVec(1'b0, 12'hA53, 639, 0);
    vecs[2]  = mkVec(1'b0, 12'hA53, 640, 0);
    vecs[3]  = mkVec(1'b1, 12'hA53, 0,   1);
    vecs[4]  = mkVec(1'b1, 12'hA53, 80,  1);
    vecs[5]  = mkVec(1'b1, 12'hA53, 160, 1);
    vecs[6]  = mkVec(1'b1, 12'hA53, 479, 1);
    vecs[7]  = mkVec(1'b1, 12'hA53, 560, 1);
    vecs[8]  = mkVec(1'b1, 12'hA53, 639, 1);
    vecs[9]  = mkVec(1'b0, 12'h123, 100, 3);
    vecs[10] = mkVec(1'b0, 12'h123, 100, 4);
    vecs[11] = mkVec(1'b1, 12'hFFF, 700, 6);
    vecs[12] = mkVec(1'b0, 12'h5A3, 799, 6);

    rst_a = 1'b1;
    rst_bc = 1'b1;
    a_test_mode = vecs[0].tm;
    a_r_in = vecs[0].rgb_in[11:8];
    a_g_in = vecs[0].rgb_in[7:4];
    a_b_in = vecs[0].rgb_in[3:0];
    repeat (3) @(posedge clk);
    @(negedge clk);
    #2;
    rst_a = 1'b0;
    rst_bc = 1'b0;

    $display("[TB] colour and bar vectors on instance A");
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i], found);
      if (!found) begin
        timeout($sformatf("vec%0d_wait", i));
      end else begin
        @(posedge clk);
        #1;
        checkOutput($sformatf("vec%0d_de_rgb", i), 64'({a_de, a_r, a_g, a_b}),
                    64'({vecs[i].de, vecs[i].rgb}), '1);
      end
    end

    $display("[TB] hsync width and line period on instance A");
    found = 1'b0;
    prev = a_hsync;
    for (int i = 0; i < WAIT_LIMIT && !found; i++) begin
      @(negedge clk);
      if (prev && !a_hsync) found = 1'b1;
      prev = a_hsync;
    end
    if (!found) begin
      timeout("hsync_fall");
    end else begin
      checkOutput("hsync_fall_x", 64'(a_x), 64'(657), '1);
      elapsed = 0;
      low_len = 0;
      found = 1'b0;
      prev = a_hsync;
      for (int i = 0; i < WAIT_LIMIT && !found; i++) begin
        @(negedge clk);
        elapsed++;
        if (!prev && a_hsync) low_len = elapsed;
        if (prev && !a_hsync) found = 1'b1;
        prev = a_hsync;
      end
      if (!found) timeout("hsync_next_fall");
      else begin
        checkOutput("hsync_low_clk", 64'(low_len), 64'(384), '1);
        checkOutput("line_period_clk", 64'(elapsed), 64'(3200), '1);
      end
    end

    $display("[TB] frame period on instance B");
    found = 1'b0;
    for (int i = 0; i < WAIT_LIMIT && !found; i++) begin
      @(negedge clk);
      if (b_frame_start) found = 1'b1;
    end
    if (!found) begin
      timeout("b_frame_start");
    end else begin
      checkOutput("b_frame_xy", 64'({b_x, b_y}), 64'(0), '1);
      elapsed = 0;
      found = 1'b0;
      for (int i = 0; i < WAIT_LIMIT && !found; i++) begin
        @(negedge clk);
        elapsed++;
        if (b_frame_start) found = 1'b1;
      end
      if (!found) timeout("b_frame_next");
      else checkOutput("b_frame_period", 64'(elapsed), 64'(98), '1);
    end

    $display("[TB] reset mid-frame on instance A");
    found = 1'b0;
    for (int i = 0; i < WAIT_LIMIT && !found; i++) begin
      @(negedge clk);
      if (int'(a_x) == 300 && int'(a_y) == 2) found = 1'b1;
    end
    if (!found) begin
      timeout("a_pos_300_2");
    end else begin
      #2;
      rst_a = 1'b1;
      #1;
      checkOutput("async_reset_state",
                  64'({a_x, a_y, a_pix_en, a_hsync, a_vsync, a_de, a_frame_start, a_r, a_g, a_b}),
                  64'({10'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 12'h000}), '1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      #2;
      rst_a = 1'b0;
      elapsed = 0;
      found = 1'b0;
      for (int i = 0; i < WAIT_LIMIT && !found; i++) begin
        @(negedge clk);
        elapsed++;
        if (a_frame_start) found = 1'b1;
      end
      if (!found) timeout("a_frame_after_reset");
      else checkOutput("a_first_frame_clk", 64'(elapsed), 64'(22400), '1);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
